ahb_sram_ctrl: RTL and testbench

- AHB-Lite slave that converts MIPSfpga bus transfers into timed, multi-cycle accesses on the board's 48-bit asynchronous SRAM pin interface. The SRAM is three 16-bit chips.
- It is the bus-side initiator for the SRAM pin-driver block. It drives word address, per-byte write enables and write data into that block, and samples the returned read data.
- Only the lower 32 bits (chips 0 and 1) carry bus data. Chip 2 is never written and its read data is ignored.

---
 rtl/ahb_sram_ctrl.sv | 142 ++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave that drives the async SRAM pin driver. A read stalls the bus READ_WAIT cycles and a write stalls it WRITE_WAIT+2 cycles.
// Backpressure is HREADYOUT, held low from accept until RESP. All outputs are registered.
module ahb_sram_ctrl #(
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2,
    parameter int CW         = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [19:0] sram_addr,
    output logic [5:0]  sram_we,
    output logic [47:0] sram_wdata,
    input  logic [47:0] sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RESP
    } state_t;

    localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_WAIT - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_mask;
    logic          r_write;
    logic          r_ready;
    logic [31:0]   r_rdata;
    logic [19:0]   r_addr;
    logic [5:0]    r_we;
    logic [47:0]   r_wdata;

    logic          w_accept;
    logic [3:0]    w_mask;
    logic          w_unused;

    // Only IDLE and RESP present HREADYOUT=1, so only they may accept.
    assign w_accept = HSEL & HTRANS[1] & HREADY &
                      ((r_state == S_IDLE) | (r_state == S_RESP));

    always_comb begin
        w_mask = 4'b1111;
        if (HSIZE == 3'd0) begin
            w_mask = 4'b0001 << HADDR[1:0];
        end else if (HSIZE == 3'd1) begin
            w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_write <= 1'b0;
            r_ready <= 1'b1;
            r_rdata <= '0;
            r_addr  <= '0;
            r_we    <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_addr  <= HADDR[21:2];
                        r_mask  <= w_mask;
                        r_write <= HWRITE;
                        r_ready <= 1'b0;
                        if (HWRITE) begin
                            r_state <= S_WR_SETUP;
                        end else begin
                            r_state <= S_RD;
                            r_cnt   <= RD_LOAD;
                        end
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (r_cnt == '0) begin
                        r_rdata <= sram_rdata[31:0];
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WR_SETUP: begin
                    // HWDATA is valid in the first data-phase cycle.
                    r_wdata <= {16'h0, HWDATA};
                    r_we    <= {2'b00, r_mask};
                    r_cnt   <= WR_LOAD;
                    r_state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (r_cnt == '0) begin
                        r_we    <= '0;
                        r_state <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WR_HOLD: begin
                    r_ready <= 1'b1;
                    r_state <= S_RESP;
                end
                default: begin
                    r_we    <= '0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign HRDATA     = r_rdata;
    assign HREADYOUT  = r_ready;
    assign HRESP      = 1'b0;
    assign sram_addr  = r_addr;
    assign sram_we    = r_we;
    assign sram_wdata = r_wdata;

    // Ignored address bits, chip-2 read data and the captured direction.
    assign w_unused = ^{HADDR[31:22], sram_rdata[47:32], HTRANS[0], r_write};

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: directed and random AHB transfers against a byte-lane memory model,
// with a behavioural async SRAM attached to the pin side.
`timescale 1ns/1ps
module tb_ahb_sram_ctrl;
    localparam int RW    = 2;
    localparam int WW    = 2;
    localparam int NRAND = 120;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [19:0] sram_addr;
    logic [5:0]  sram_we;
    logic [47:0] sram_wdata;
    logic [47:0] sram_rdata;

    logic [47:0] pin_mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] last_rd;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    txn_t txq[$];

    ahb_sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW), .CW(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 HCLK = ~HCLK;

    // Single-slave bus: the bus-wide ready is this slave's ready.
    assign HREADY     = HREADYOUT;
    assign sram_rdata = pin_mem[sram_addr[7:0]];

    always @(negedge HCLK) begin
        for (int b = 0; b < 6; b++)
            if (sram_we[b]) pin_mem[sram_addr[7:0]][8*b +: 8] = sram_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] sz);
        logic [3:0] m;
        int nb;
        int base;
        m    = '0;
        nb   = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        base = (int'(a[1:0]) / nb) * nb;
        for (int b = 0; b < nb; b++) m[base + b] = 1'b1;
        return m;
    endfunction

    task automatic put_addr(input txn_t t);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = t.addr;
        HWRITE = t.wr;
        HSIZE  = t.size;
    endtask

    task automatic put_idle();
        case ($urandom_range(2))
            0:       begin HSEL = 1'b0; HTRANS = 2'b10; end
            1:       begin HSEL = 1'b1; HTRANS = 2'b00; end
            default: begin HSEL = 1'b1; HTRANS = 2'b01; end
        endcase
        HADDR  = 32'($urandom);
        HWRITE = 1'($urandom);
        HSIZE  = 3'($urandom);
    endtask

    // Entered at a negedge with t's address phase on the bus and HREADYOUT high.
    task automatic run_txn(input txn_t t, input bit has_next, input txn_t nt);
        int low    = 0;
        int we_err = 0;
        int ad_err = 0;
        int wd_err = 0;
        logic [3:0] m;
        logic [5:0] exp_we;
        logic [7:0] idx;
        m   = lanes(t.addr, t.size);
        idx = t.addr[9:2];
        @(posedge HCLK);
        @(negedge HCLK);
        HWDATA = t.wdata;
        if (has_next && t.gap == 0) put_addr(nt);
        else put_idle();
        while (!HREADYOUT && low < 40) begin
            exp_we = (t.wr && low >= 1 && low <= WW) ? {2'b00, m} : 6'd0;
            if (sram_we !== exp_we) we_err++;
            if (sram_addr !== t.addr[21:2]) ad_err++;
            if (t.wr && low >= 1 && sram_wdata !== {16'h0, t.wdata}) wd_err++;
            low++;
            @(negedge HCLK);
        end
        chk("low_cycles", 64'(low), t.wr ? 64'(WW + 2) : 64'(RW));
        chk("we_pattern", 64'(we_err), 64'd0);
        chk("addr_hold", 64'(ad_err), 64'd0);
        chk("resp_we", 64'(sram_we), 64'd0);
        if (t.wr) begin
            chk("wdata", 64'(wd_err), 64'd0);
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[idx][8*b +: 8] = t.wdata[8*b +: 8];
            chk("hrdata_hold", 64'(HRDATA), 64'(last_rd));
        end else begin
            last_rd = ref_mem[idx];
            chk("hrdata", 64'(HRDATA), 64'(last_rd));
        end
        for (int k = 0; k < t.gap; k++) begin
            @(negedge HCLK);
            chk("idle_rdy", 64'(HREADYOUT), 64'd1);
            chk("idle_we", 64'(sram_we), 64'd0);
            if (k == t.gap - 1 && has_next) put_addr(nt);
            else put_idle();
        end
    endtask

    task automatic run_queue();
        txn_t nt;
        bit   has_next;
        @(negedge HCLK);
        put_addr(txq[0]);
        for (int i = 0; i < txq.size(); i++) begin
            has_next = (i + 1 < txq.size());
            nt = has_next ? txq[i + 1] : txq[i];
            run_txn(txq[i], has_next, nt);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                                input logic [31:0] d, input int g);
        txn_t t;
        t.addr = a; t.wr = w; t.size = s; t.wdata = d; t.gap = g;
        return t;
    endfunction

    initial begin
        txn_t t;
        logic [7:0] xi;
        int   wait_cnt;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'($urandom);
            pin_mem[i] = {16'($urandom), ref_mem[i]};
        end
        pin_mem[4][47:32] = 16'h1234;
        last_rd = '0;
        HWDATA  = '0;
        HRESETn = 1'b0;
        put_idle();
        repeat (2) @(negedge HCLK);
        chk("rst_rdy", 64'(HREADYOUT), 64'd1);
        chk("rst_we", 64'(sram_we), 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_hrdata", 64'(HRDATA), 64'd0);
        chk("rst_wdata", 64'(sram_wdata), 64'd0);
        chk("rst_hresp", 64'(HRESP), 64'd0);
        HRESETn = 1'b1;

        txq.push_back(mk(32'h0000_0010, 1'b1, 3'd2, 32'hDEADBEEF, 0));
        txq.push_back(mk(32'h0000_0010, 1'b0, 3'd2, 32'h0, 1));
        txq.push_back(mk(32'h0000_0013, 1'b1, 3'd0, 32'hA5A5_A5A5, 0));
        txq.push_back(mk(32'h0000_0002, 1'b1, 3'd1, 32'h5A5A_C3C3, 0));
        txq.push_back(mk(32'h0000_0001, 1'b1, 3'd1, 32'h1357_9BDF, 2));
        txq.push_back(mk(32'h0000_0020, 1'b0, 3'd2, 32'h0, 0));
        txq.push_back(mk(32'h0000_0024, 1'b1, 3'd2, 32'hCAFE_F00D, 3));
        txq.push_back(mk(32'h0000_0010, 1'b0, 3'd2, 32'h0, 0));
        txq.push_back(mk(32'h0000_0000, 1'b0, 3'd2, 32'h0, 0));
        for (int i = 0; i < NRAND; i++) begin
            t.addr  = {10'($urandom), 12'h0, 8'($urandom_range(15)), 2'($urandom)};
            t.wr    = 1'($urandom);
            t.size  = 3'($urandom);
            t.wdata = 32'($urandom);
            t.gap   = ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 3);
            txq.push_back(t);
        end
        run_queue();

        // Reset in the middle of a write pulse; the write carries unchanged data.
        xi = 8'd9;
        @(negedge HCLK);
        put_addr(mk({24'h0, xi, 2'b00}, 1'b1, 3'd2, 32'h0, 0));
        @(posedge HCLK);
        @(negedge HCLK);
        HWDATA = ref_mem[xi];
        put_idle();
        wait_cnt = 0;
        while (sram_we == 6'd0 && wait_cnt < 10) begin
            wait_cnt++;
            @(negedge HCLK);
        end
        chk("pulse_seen", 64'(sram_we), 64'h0F);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_rdy", 64'(HREADYOUT), 64'd1);
        chk("arst_we", 64'(sram_we), 64'd0);
        chk("arst_addr", 64'(sram_addr), 64'd0);
        chk("arst_hrdata", 64'(HRDATA), 64'd0);
        chk("arst_wdata", 64'(sram_wdata), 64'd0);
        last_rd = '0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        txq.delete();
        txq.push_back(mk({24'h0, xi, 2'b00}, 1'b1, 3'd0, 32'h0000_0077, 0));
        txq.push_back(mk({24'h0, xi, 2'b00}, 1'b0, 3'd2, 32'h0, 0));
        txq.push_back(mk(32'h0000_0010, 1'b0, 3'd2, 32'h0, 1));
        run_queue();

        repeat (2) @(negedge HCLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
